// File: rtl/tick_sched.sv
// tick_sched: shared delay-timer scheduler.
// One prescaler (sys_clk -> TICK_FREQ tick) and one countdown, time-shared
// between N_REQ requesters through a round-robin arbiter. Each winner gets a
// one-shot delay of dly ticks followed by a single-cycle done pulse.
// Ports:
//   sys_clk  system clock, rising edge
//   rst_n    asynchronous active-low reset
//   req      level request per client, held until done or withdrawn
//   dly      packed delays, client i at [i*DLY_W +: DLY_W], sampled at grant
//   gnt      one-hot registered grant, zero when idle
//   done     one-cycle registered completion pulse for the served client
//   busy     high whenever the scheduler is not idle
//   tick     prescaler tick pulse, only while counting
module tick_sched #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int TICK_FREQ = 5_000,
    parameter int N_REQ     = 4,
    parameter int DLY_W     = 16
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DLY_W-1:0]   dly,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic                     busy,
    output logic                     tick
);
    localparam int TICK_DIV = CLK_FREQ / TICK_FREQ;
    localparam int PW       = $clog2(TICK_DIV);
    localparam int IW       = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [PW-1:0]      pre_q, pre_d;
    logic [DLY_W-1:0]   rem_q, rem_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      win_q, win_d;

    logic               arb_hit;
    logic [IW-1:0]      arb_idx;
    logic [N_REQ-1:0]   arb_oh;
    logic [DLY_W-1:0]   arb_dly;
    logic               tick_w;

    // Round-robin search starting just after the last served client.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = ptr_q;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!arb_hit && req[(int'(ptr_q) + k) % N_REQ]) begin
                arb_hit = 1'b1;
                arb_idx = IW'((int'(ptr_q) + k) % N_REQ);
            end
        end
    end

    assign arb_oh  = N_REQ'(1) << arb_idx;
    assign arb_dly = dly[arb_idx*DLY_W +: DLY_W];
    assign tick_w  = (state_q == COUNT) && (pre_q == PW'(TICK_DIV - 1));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = done_q;
        pre_d   = pre_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        case (state_q)
            IDLE: begin
                if (arb_hit) begin
                    gnt_d   = arb_oh;
                    win_d   = arb_idx;
                    rem_d   = arb_dly;
                    pre_d   = '0;
                    // A zero delay completes immediately without counting.
                    state_d = (arb_dly != '0) ? COUNT : DONE;
                    done_d  = (arb_dly != '0) ? '0 : arb_oh;
                end
            end
            COUNT: begin
                if (!req[win_q]) begin
                    // Withdrawn: abandon silently, client drops to lowest priority.
                    gnt_d   = '0;
                    pre_d   = '0;
                    ptr_d   = win_q;
                    state_d = IDLE;
                end else if (tick_w) begin
                    pre_d = '0;
                    rem_d = rem_q - DLY_W'(1);
                    if (rem_q == DLY_W'(1)) begin
                        state_d = DONE;
                        done_d  = gnt_q;
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            DONE: begin
                done_d  = '0;
                gnt_d   = '0;
                ptr_d   = win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            pre_q   <= '0;
            rem_q   <= '0;
            ptr_q   <= IW'(N_REQ - 1);
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            pre_q   <= pre_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = (state_q != IDLE);
    assign tick = tick_w;
endmodule
